// File: rtl/mem_stage_sram_ctrl_if.sv
// Bus bundle between the EXE->MEM pipeline register, the MEM-stage SRAM
// controller and the external asynchronous 16-bit SRAM pads.
// Optional feature macro: SRAM_ALIGN_CHECK_EN (adds align_err).
//
// Handshake: MEM_R_EN / MEM_W_EN act as a level "valid" that the pipeline
// holds, together with ALU_Res and Val_Rm, for as long as ready is 0. A request
// is complete on the first cycle that shows valid and ready=1 together. The
// pipeline may then drop the request or present the next one.
interface mem_stage_sram_ctrl_if #(
    parameter int ADDRESS_LEN = 32,
    parameter int SRAM_ADDR_W = 18,
    parameter int SRAM_DATA_W = 16
);
    // pipeline side
    logic [ADDRESS_LEN-1:0] ALU_Res;
    logic [ADDRESS_LEN-1:0] Val_Rm;
    logic                   MEM_R_EN;
    logic                   MEM_W_EN;
    logic                   ready;
    logic [ADDRESS_LEN-1:0] Mem_Read_Value;
    // SRAM pad side
    logic [SRAM_ADDR_W-1:0] sram_addr;
    logic [SRAM_DATA_W-1:0] sram_dq_out;
    logic [SRAM_DATA_W-1:0] sram_dq_in;
    logic                   sram_dq_oe;
    logic                   sram_we_n;
    logic                   sram_oe_n;
`ifdef SRAM_ALIGN_CHECK_EN
    logic                   align_err;
`endif

    // controller view
    modport slave (
        input  ALU_Res, Val_Rm, MEM_R_EN, MEM_W_EN, sram_dq_in,
        output ready, Mem_Read_Value, sram_addr, sram_dq_out,
               sram_dq_oe, sram_we_n, sram_oe_n
`ifdef SRAM_ALIGN_CHECK_EN
        , output align_err
`endif
    );

    // pipeline + SRAM view
    modport master (
        output ALU_Res, Val_Rm, MEM_R_EN, MEM_W_EN, sram_dq_in,
        input  ready, Mem_Read_Value, sram_addr, sram_dq_out,
               sram_dq_oe, sram_we_n, sram_oe_n
`ifdef SRAM_ALIGN_CHECK_EN
        , input align_err
`endif
    );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage SRAM controller: each 32-bit load/store is split into a LOW and a
// HIGH 16-bit access on an asynchronous SRAM. ready is held low to freeze the
// pipeline until the access is done. All SRAM pad outputs are registered, so
// they are computed from the next state and change only on clock edges.
// Optional feature macro: SRAM_ALIGN_CHECK_EN (misaligned requests skip the
// SRAM and pulse align_err).
module mem_stage_sram_ctrl #(
    parameter int ADDRESS_LEN = 32,
    parameter int SRAM_ADDR_W = 18,
    parameter int SRAM_DATA_W = 16,
    parameter int WAIT_CYCLES = 1,
    parameter int MEM_BASE    = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    mem_stage_sram_ctrl_if.slave      bus,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CNT_W  = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam int WORD_W = SRAM_ADDR_W - 1;
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(WAIT_CYCLES);
    localparam logic [ADDRESS_LEN-1:0] BASE     = ADDRESS_LEN'(MEM_BASE);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   is_write_q, is_write_d;
    logic [WORD_W-1:0]      word_q, word_d;
    logic [SRAM_DATA_W-1:0] data_hi_q, data_hi_d;

    logic [SRAM_ADDR_W-1:0] addr_d;
    logic [SRAM_DATA_W-1:0] dq_out_d;
    logic                   in_phase_d;
    logic                   we_n_d, oe_n_d, dq_oe_d;
`ifdef SRAM_ALIGN_CHECK_EN
    logic                   align_d;
`endif

    logic                   req;
    logic [ADDRESS_LEN-1:0] off;
    logic                   unused_off_bits;

    assign req = bus.MEM_R_EN | bus.MEM_W_EN;
    // Base subtraction wraps; only the word-index bits reach the SRAM.
    assign off = bus.ALU_Res - BASE;
    assign unused_off_bits = ^{off[ADDRESS_LEN-1:SRAM_ADDR_W+1], off[1:0]};
    assign dbg_state = state_q;

    // Next-state logic, request latching and the ready handshake.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        word_d     = word_q;
        data_hi_d  = data_hi_q;
        bus.ready  = 1'b0;
`ifdef SRAM_ALIGN_CHECK_EN
        align_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                bus.ready = ~req;
                if (req) begin
                    // store wins when both enables are set
                    is_write_d = bus.MEM_W_EN;
                    word_d     = off[SRAM_ADDR_W:2];
                    data_hi_d  = bus.Val_Rm[ADDRESS_LEN-1:SRAM_DATA_W];
                    cnt_d      = '0;
`ifdef SRAM_ALIGN_CHECK_EN
                    if (bus.ALU_Res[1:0] != 2'b00) begin
                        state_d = DONE;
                        align_d = 1'b1;
                    end else begin
                        state_d = LOW;
                    end
`else
                    state_d    = LOW;
`endif
                end
            end
            LOW: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // unconditional return so a still-held request is not re-issued
                bus.ready = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered SRAM pad outputs.
    always_comb begin
        addr_d     = bus.sram_addr;
        dq_out_d   = bus.sram_dq_out;
        in_phase_d = (state_d == LOW) || (state_d == HIGH);
        if (state_d == LOW) begin
            addr_d = {word_d, 1'b0};
        end else if (state_d == HIGH) begin
            addr_d = {word_d, 1'b1};
        end
        if (state_q == IDLE && state_d == LOW) begin
            dq_out_d = bus.Val_Rm[SRAM_DATA_W-1:0];
        end else if (state_q == LOW && state_d == HIGH) begin
            dq_out_d = data_hi_q;
        end
        // write strobe released in the last phase cycle for data hold
        we_n_d  = ~(is_write_d & in_phase_d & (cnt_d != CNT_LAST));
        oe_n_d  = ~(~is_write_d & in_phase_d);
        dq_oe_d = is_write_d & in_phase_d;
    end

    // FSM state, latched request and registered SRAM pad outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            is_write_q      <= 1'b0;
            word_q          <= '0;
            data_hi_q       <= '0;
            bus.sram_addr   <= '0;
            bus.sram_dq_out <= '0;
            bus.sram_dq_oe  <= 1'b0;
            bus.sram_we_n   <= 1'b1;
            bus.sram_oe_n   <= 1'b1;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            is_write_q      <= is_write_d;
            word_q          <= word_d;
            data_hi_q       <= data_hi_d;
            bus.sram_addr   <= addr_d;
            bus.sram_dq_out <= dq_out_d;
            bus.sram_dq_oe  <= dq_oe_d;
            bus.sram_we_n   <= we_n_d;
            bus.sram_oe_n   <= oe_n_d;
        end
    end

    // Load data capture on the edge ending each phase's last cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.Mem_Read_Value <= '0;
        end else if (!is_write_q && cnt_q == CNT_LAST) begin
            if (state_q == LOW) begin
                bus.Mem_Read_Value[SRAM_DATA_W-1:0] <= bus.sram_dq_in;
            end else if (state_q == HIGH) begin
                bus.Mem_Read_Value[ADDRESS_LEN-1:SRAM_DATA_W] <= bus.sram_dq_in;
            end
        end
    end

`ifdef SRAM_ALIGN_CHECK_EN
    // Misalignment pulse, high only in the DONE cycle of a rejected request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.align_err <= 1'b0;
        end else begin
            bus.align_err <= align_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a behavioural SRAM model and a
// write scoreboard (expected {addr,data} per write-strobe cycle).
module tb_mem_stage_sram_ctrl;

    localparam int ADDRESS_LEN = 32;
    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q[$];
    logic [15:0] mem [0:(1<<SRAM_ADDR_W)-1];

    mem_stage_sram_ctrl_if #(
        .ADDRESS_LEN(ADDRESS_LEN), .SRAM_ADDR_W(SRAM_ADDR_W), .SRAM_DATA_W(SRAM_DATA_W)
    ) bus ();

    mem_stage_sram_ctrl #(
        .ADDRESS_LEN(ADDRESS_LEN), .SRAM_ADDR_W(SRAM_ADDR_W), .SRAM_DATA_W(SRAM_DATA_W),
        .WAIT_CYCLES(1), .MEM_BASE(1024)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // SRAM model: asynchronous read, write captured while we_n is low
    assign bus.sram_dq_in = !bus.sram_oe_n ? mem[bus.sram_addr] : 16'h0000;
    always @(posedge clk) begin
        if (!bus.sram_we_n && bus.sram_dq_oe) mem[bus.sram_addr] <= bus.sram_dq_out;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: every write-strobe cycle must match the next expected write
    always @(posedge clk) begin
        if (rst && !bus.sram_we_n) begin
            logic [63:0] exp_w;
            exp_w = (exp_q.size() > 0) ? {30'd0, exp_q.pop_front()} : 64'hFFFF_FFFF_FFFF_FFFF;
            check_eq("sram_write", {30'd0, bus.sram_addr, bus.sram_dq_out}, exp_w);
        end
    end

    // driver: present a request after an edge, count ready-low cycles until DONE
    task automatic do_req(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int lo);
        @(posedge clk); #1;
        bus.MEM_R_EN = r;
        bus.MEM_W_EN = w;
        bus.ALU_Res  = a;
        bus.Val_Rm   = d;
        lo = 0;
        while (lo < 40) begin
            @(negedge clk);
            if (bus.ready) break;
            lo++;
            @(posedge clk); #1;
        end
    endtask

    task automatic drop_req();
        @(posedge clk); #1;
        bus.MEM_R_EN = 1'b0;
        bus.MEM_W_EN = 1'b0;
    endtask

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lo;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        mem[2] = 16'hCAFE;
        mem[3] = 16'hF00D;
        bus.MEM_R_EN = 1'b1;
        bus.MEM_W_EN = 1'b0;
        bus.ALU_Res  = 32'd1028;
        bus.Val_Rm   = 32'd0;

        // reset held with a load request present
        repeat (2) @(negedge clk);
        check_eq("rst_ready", {63'd0, bus.ready}, 64'd0);
        check_eq("rst_we_n", {63'd0, bus.sram_we_n}, 64'd1);
        check_eq("rst_oe_n", {63'd0, bus.sram_oe_n}, 64'd1);
        check_eq("rst_dq_oe", {63'd0, bus.sram_dq_oe}, 64'd0);
        check_eq("rst_rdval", {32'd0, bus.Mem_Read_Value}, 64'd0);
        check_eq("rst_addr", {46'd0, bus.sram_addr}, 64'd0);
        check_eq("rst_state", {62'd0, dbg_state}, 64'd0);

        // release: the load starts on the next edge
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("load0_state_low", {62'd0, dbg_state}, 64'd1);
        check_eq("load0_oe_n", {63'd0, bus.sram_oe_n}, 64'd0);
        check_eq("load0_addr", {46'd0, bus.sram_addr}, 64'd2);
        lo = 0;
        while (lo < 40) begin
            @(negedge clk);
            if (bus.ready) break;
            lo++;
        end
        check_eq("load0_lat", lo, 64'd4);
        check_eq("load0_data", {32'd0, bus.Mem_Read_Value}, 64'hF00DCAFE);

        // store back-to-back after the load's DONE
        exp_q.push_back({18'd2, 16'hBEEF});
        exp_q.push_back({18'd3, 16'hDEAD});
        do_req(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, lo);
        check_eq("store_lat", lo, 64'd5);
        check_eq("store_keeps_rdval", {32'd0, bus.Mem_Read_Value}, 64'hF00DCAFE);
        check_eq("store_strobes_left", exp_q.size(), 64'd0);

        // load back, presented on the store's DONE-following cycle
        do_req(1'b1, 1'b0, 32'd1028, 32'd0, lo);
        check_eq("load1_lat", lo, 64'd5);
        check_eq("load1_data", {32'd0, bus.Mem_Read_Value}, 64'hDEADBEEF);

        // both enables: store wins
        exp_q.push_back({18'd4, 16'h5678});
        exp_q.push_back({18'd5, 16'h1234});
        do_req(1'b1, 1'b1, 32'd1032, 32'h1234_5678, lo);
        check_eq("both_lat", lo, 64'd5);
        check_eq("both_keeps_rdval", {32'd0, bus.Mem_Read_Value}, 64'hDEADBEEF);
        check_eq("both_strobes_left", exp_q.size(), 64'd0);

        do_req(1'b1, 1'b0, 32'd1032, 32'd0, lo);
        check_eq("load2_lat", lo, 64'd5);
        check_eq("load2_data", {32'd0, bus.Mem_Read_Value}, 64'h12345678);

        // idle with no request
        drop_req();
        @(negedge clk);
        check_eq("idle_ready", {63'd0, bus.ready}, 64'd1);
        check_eq("idle_state", {62'd0, dbg_state}, 64'd0);
        check_eq("idle_we_n", {63'd0, bus.sram_we_n}, 64'd1);

        // async reset during HIGH of a store
        exp_q.push_back({18'd6, 16'h3333});
        @(posedge clk); #1;
        bus.MEM_W_EN = 1'b1;
        bus.ALU_Res  = 32'd1036;
        bus.Val_Rm   = 32'hAAAA_3333;
        lo = 0;
        while (lo < 40) begin
            @(negedge clk);
            if (dbg_state == 2'd2) break;
            lo++;
        end
        check_eq("abort_reach_high", lo, 64'd3);
        check_eq("abort_high_we_n", {63'd0, bus.sram_we_n}, 64'd0);
        #1 rst = 1'b0;
        #1;
        check_eq("abort_we_n", {63'd0, bus.sram_we_n}, 64'd1);
        check_eq("abort_state", {62'd0, dbg_state}, 64'd0);
        check_eq("abort_dq_oe", {63'd0, bus.sram_dq_oe}, 64'd0);
        bus.MEM_W_EN = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_after_ready", {63'd0, bus.ready}, 64'd1);
        check_eq("abort_after_state", {62'd0, dbg_state}, 64'd0);
        check_eq("abort_strobes_left", exp_q.size(), 64'd0);

`ifdef SRAM_ALIGN_CHECK_EN
        // misaligned store goes straight to DONE, SRAM untouched
        do_req(1'b0, 1'b1, 32'd1026, 32'h5555_5555, lo);
        check_eq("align_lat", lo, 64'd1);
        check_eq("align_err_done", {63'd0, bus.align_err}, 64'd1);
        check_eq("align_rdval", {32'd0, bus.Mem_Read_Value}, 64'h12345678);
        drop_req();
        @(negedge clk);
        check_eq("align_err_clear", {63'd0, bus.align_err}, 64'd0);
`else
        // misaligned load is word-truncated to the same halfword pair
        do_req(1'b1, 1'b0, 32'd1030, 32'd0, lo);
        check_eq("trunc_lat", lo, 64'd5);
        check_eq("trunc_data", {32'd0, bus.Mem_Read_Value}, 64'hDEADBEEF);
        drop_req();
        @(negedge clk);
`endif
        check_eq("final_strobes_left", exp_q.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
